// File: rtl/regfile_pkg.sv
// Shared constants and the queued writeback entry type for the integer register file slice.
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int REG_ID_W  = 5;
    localparam int REG_COUNT = 32;

    typedef struct packed {
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_bypass_match.sv
// Scans the occupied queue slots from head towards tail and reports the youngest entry
// whose destination matches the requested operand id (x0 never matches).
module regfile_bypass_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wb_entry_t [DEPTH-1:0] ents,
    input  logic [PTR_W-1:0]      head,
    input  logic [CNT_W-1:0]      occupied,
    input  logic [REG_ID_W-1:0]   lookup_id,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic [PTR_W-1:0] idx_s;
    logic             match_s;

    // Later (younger) matches overwrite earlier ones, so the result is the entry nearest the tail.
    always_comb begin
        hit     = 1'b0;
        data    = {XLEN{1'b0}};
        idx_s   = {PTR_W{1'b0}};
        match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s   = head + PTR_W'(i);
            match_s = (CNT_W'(i) < occupied) &&
                      (ents[idx_s].rd == lookup_id) &&
                      (lookup_id != {REG_ID_W{1'b0}});
            hit     = hit | match_s;
            data    = match_s ? ents[idx_s].data : data;
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// FIFO of writeback results draining into the register file write port, one per cycle.
// Optional operand forwarding from queued entries is enabled by defining WB_BYPASS_EN.
module regfile_writeback_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int XLEN     = regfile_pkg::XLEN,
    parameter int REG_ID_W = regfile_pkg::REG_ID_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_ID_W-1:0]        in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       drain_hold,
    output logic                       rf_write_en,
    output logic [REG_ID_W-1:0]        rf_write_id,
    output logic [XLEN-1:0]            rf_write_data,
    input  logic [REG_ID_W-1:0]        lookup1_id,
    input  logic [REG_ID_W-1:0]        lookup2_id,
    output logic                       lookup1_hit,
    output logic [XLEN-1:0]            lookup1_data,
    output logic                       lookup2_hit,
    output logic [XLEN-1:0]            lookup2_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    wb_entry_t [DEPTH-1:0]  mem_q, mem_d;

    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_s;

    // Handshake, pointer and occupancy next-state; x0 results complete the handshake but are dropped.
    always_comb begin
        empty_s  = (count_q == CNT_W'(0));
        full_s   = (count_q == CNT_W'(DEPTH));
        pop_s    = !empty_s && !drain_hold;
        in_ready = !full_s || pop_s;
        push_s   = in_valid && in_ready && (in_rd != {REG_ID_W{1'b0}});

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            mem_d[wr_ptr_q].rd   = in_rd;
            mem_d[wr_ptr_q].data = in_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Head entry presented straight to the write port; zeros whenever no write occurs.
    always_comb begin
        rf_write_en = pop_s;
        if (pop_s) begin
            rf_write_id   = mem_q[rd_ptr_q].rd;
            rf_write_data = mem_q[rd_ptr_q].data;
        end else begin
            rf_write_id   = {REG_ID_W{1'b0}};
            rf_write_data = {XLEN{1'b0}};
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left uncleared; occupancy alone qualifies it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;

`ifdef WB_BYPASS_EN
    regfile_bypass_match #(
        .DEPTH (DEPTH)
    ) u_match1 (
        .ents      (mem_q),
        .head      (rd_ptr_q),
        .occupied  (count_q),
        .lookup_id (lookup1_id),
        .hit       (lookup1_hit),
        .data      (lookup1_data)
    );

    regfile_bypass_match #(
        .DEPTH (DEPTH)
    ) u_match2 (
        .ents      (mem_q),
        .head      (rd_ptr_q),
        .occupied  (count_q),
        .lookup_id (lookup2_id),
        .hit       (lookup2_hit),
        .data      (lookup2_data)
    );
`else
    logic unused_lookup_s;
    assign unused_lookup_s = ^{lookup1_id, lookup2_id};
    assign lookup1_hit     = 1'b0;
    assign lookup1_data    = {XLEN{1'b0}};
    assign lookup2_hit     = 1'b0;
    assign lookup2_data    = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench: stimulus pushes expected register-file writes, a negedge monitor checks them.
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_hold;
    logic        rf_write_en;
    logic [4:0]  rf_write_id;
    logic [31:0] rf_write_data;
    logic [4:0]  lookup1_id;
    logic [4:0]  lookup2_id;
    logic        lookup1_hit;
    logic [31:0] lookup1_data;
    logic        lookup2_hit;
    logic [31:0] lookup2_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    logic [36:0] exp_q[$];

    regfile_writeback_queue #(.DEPTH(4), .XLEN(32), .REG_ID_W(5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_data       (in_data),
        .drain_hold    (drain_hold),
        .rf_write_en   (rf_write_en),
        .rf_write_id   (rf_write_id),
        .rf_write_data (rf_write_data),
        .lookup1_id    (lookup1_id),
        .lookup2_id    (lookup2_id),
        .lookup1_hit   (lookup1_hit),
        .lookup1_data  (lookup1_data),
        .lookup2_hit   (lookup2_hit),
        .lookup2_data  (lookup2_data),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one result; required in_ready is checked mid-cycle, then the edge completes it.
    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic exp_ready);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = data;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        if (exp_ready && rd != 5'd0) exp_q.push_back({rd, data});
        step();
        in_valid = 1'b0;
        in_rd    = 5'd0;
        in_data  = 32'd0;
    endtask

    // Monitor: every register-file write must match the scoreboard head; idle port must be zero.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rf_write_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, rf_write_id}, 32'd0);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    check("write_id", {27'd0, rf_write_id}, {27'd0, e[36:32]});
                    check("write_data", rf_write_data, e[31:0]);
                end
            end else begin
                check("idle_id", {27'd0, rf_write_id}, 32'd0);
                check("idle_data", rf_write_data, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_rd      = 5'd0;
        in_data    = 32'd0;
        drain_hold = 1'b0;
        lookup1_id = 5'd0;
        lookup2_id = 5'd0;
        step();
        step();
        @(negedge clk);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_wen", {31'd0, rf_write_en}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_hit1", {31'd0, lookup1_hit}, 32'd0);
        check("rst_data2", lookup2_data, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // 1: single result, written the cycle after acceptance
        push(5'd5, 32'hDEADBEEF, 1'b1);
        step();
        @(negedge clk);
        check("t1_count", {29'd0, count}, 32'd0);
        step();

        // 2: fill under hold, then four back-to-back writes
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i), 1'b1);
        @(negedge clk);
        check("t2_count", {29'd0, count}, 32'd4);
        check("t2_ready", {31'd0, in_ready}, 32'd0);
        step();
        drain_hold = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("t2_drained", {29'd0, count}, 32'd0);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        step();

        // 3: push while full and draining
        drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'hA0 + 32'(i), 1'b1);
        drain_hold = 1'b0;
        push(5'd7, 32'h77, 1'b1);
        @(negedge clk);
        check("t3_count", {29'd0, count}, 32'd4);
        repeat (4) step();
        @(negedge clk);
        check("t3_drained", {29'd0, count}, 32'd0);
        step();

        // 4: x0 result is accepted but dropped
        push(5'd0, 32'h1234, 1'b1);
        @(negedge clk);
        check("t4_count", {29'd0, count}, 32'd0);
        repeat (2) step();

        // 5: forwarding of the youngest queued value
        drain_hold = 1'b1;
        lookup1_id = 5'd3;
        lookup2_id = 5'd0;
        push(5'd3, 32'h11, 1'b1);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t5_hit1_a", {31'd0, lookup1_hit}, 32'd1);
        check("t5_data1_a", lookup1_data, 32'h11);
`else
        check("t5_hit1_a", {31'd0, lookup1_hit}, 32'd0);
        check("t5_data1_a", lookup1_data, 32'h0);
`endif
        step();
        push(5'd3, 32'h22, 1'b1);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t5_hit1_b", {31'd0, lookup1_hit}, 32'd1);
        check("t5_data1_b", lookup1_data, 32'h22);
`else
        check("t5_hit1_b", {31'd0, lookup1_hit}, 32'd0);
        check("t5_data1_b", lookup1_data, 32'h0);
`endif
        check("t5_hit2", {31'd0, lookup2_hit}, 32'd0);
        check("t5_data2", lookup2_data, 32'd0);
        step();
        lookup2_id = 5'd9;
        drain_hold = 1'b0;
        step();
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("t5_hit1_last", {31'd0, lookup1_hit}, 32'd1);
        check("t5_data1_last", lookup1_data, 32'h22);
`else
        check("t5_hit1_last", {31'd0, lookup1_hit}, 32'd0);
        check("t5_data1_last", lookup1_data, 32'h0);
`endif
        check("t5_hit2_miss", {31'd0, lookup2_hit}, 32'd0);
        step();
        lookup1_id = 5'd0;
        lookup2_id = 5'd0;
        step();

        // 6: reset with queued entries discards them
        drain_hold = 1'b1;
        push(5'd8, 32'h88, 1'b1);
        push(5'd9, 32'h99, 1'b1);
        push(5'd10, 32'hAA, 1'b1);
        @(negedge clk);
        check("t6_count_pre", {29'd0, count}, 32'd3);
        step();
        reset_n = 1'b0;
        exp_q.delete();
        step();
        reset_n    = 1'b1;
        drain_hold = 1'b0;
        @(negedge clk);
        check("t6_count", {29'd0, count}, 32'd0);
        check("t6_wen", {31'd0, rf_write_en}, 32'd0);
        repeat (4) step();

        @(negedge clk);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
